// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch stage: PC, next-PC select, run/single-step commit gating
module ifetch_unit #(
    parameter logic [31:0] PC_RESET   = 32'h0000_0000,
    parameter int          ROM_ADDR_W = 14
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [ROM_ADDR_W-1:0] rom_adr_o,
    input  logic [31:0]           Instruction_i,
    output logic [31:0]           Instruction_o,
    input  logic                  Jr,
    input  logic                  Jmp,
    input  logic                  Jal,
    input  logic                  Branch,
    input  logic                  nBranch,
    input  logic                  Zero,
    input  logic [31:0]           Read_data_1,
    output logic [31:0]           pc_o,
    output logic [31:0]           pc_plus4_o,
    input  logic                  run_mode,
    input  logic                  step,
    output logic                  commit,
    output logic [31:0]           instr_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_STEP = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic [31:0] jr_target;
    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic [15:0] imm;
    logic        branch_taken;
    logic        step_q;
    logic        step_rise;

    assign pc_plus4      = pc + 32'd4;
    assign imm           = Instruction_i[15:0];
    assign jr_target     = Read_data_1 & 32'hFFFF_FFFC;
    assign jump_target   = {pc_plus4[31:28], Instruction_i[25:0], 2'b00};
    assign branch_target = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
    assign branch_taken  = (Branch & Zero) | (nBranch & ~Zero);

    always_comb begin
        pc_next = pc_plus4;
        if (Jr) begin
            pc_next = jr_target;
        end else if (Jmp | Jal) begin
            pc_next = jump_target;
        end else if (branch_taken) begin
            pc_next = branch_target;
        end
    end

    assign step_rise = step & ~step_q;

    // run_mode is checked before step so free-run wins when both are asserted in IDLE
    always_comb begin
        state_next = S_IDLE;
        case (state)
            S_IDLE: begin
                if (run_mode) begin
                    state_next = S_RUN;
                end else if (step_rise) begin
                    state_next = S_STEP;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_RUN:   state_next = run_mode ? S_RUN : S_IDLE;
            S_STEP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign commit = (state == S_RUN) || (state == S_STEP);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= PC_RESET;
            step_q      <= 1'b0;
            instr_count <= 32'd0;
        end else begin
            state  <= state_next;
            step_q <= step;
            if (commit) begin
                pc          <= pc_next;
                instr_count <= instr_count + 32'd1;
            end
        end
    end

    assign pc_o          = pc;
    assign pc_plus4_o    = pc_plus4;
    assign rom_adr_o     = pc[ROM_ADDR_W+1:2];
    assign Instruction_o = Instruction_i;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - self-checking bench for ifetch_unit: vector table, corner sequences, random vs model
module tb_ifetch_unit;

    localparam logic [31:0] PC_RESET = 32'h0000_0000;
    localparam int          AW       = 14;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] rom_adr_o;
    logic [31:0]   instr;
    logic [31:0]   Instruction_o;
    logic          jr, jmp, jal, br, nbr, zero;
    logic [31:0]   rd1;
    logic [31:0]   pc_o, pc_plus4_o, instr_count;
    logic          run_mode, step, commit;

    ifetch_unit #(.PC_RESET(PC_RESET), .ROM_ADDR_W(AW)) dut (
        .clock         (clock),
        .reset         (reset),
        .rom_adr_o     (rom_adr_o),
        .Instruction_i (instr),
        .Instruction_o (Instruction_o),
        .Jr            (jr),
        .Jmp           (jmp),
        .Jal           (jal),
        .Branch        (br),
        .nBranch       (nbr),
        .Zero          (zero),
        .Read_data_1   (rd1),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .run_mode      (run_mode),
        .step          (step),
        .commit        (commit),
        .instr_count   (instr_count)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef enum int {M_IDLE, M_RUN, M_STEP} mmode_t;
    mmode_t      m_mode;
    logic [31:0] m_pc, m_count;
    logic        m_step_prev;

    function automatic logic [31:0] model_target(input logic [31:0] cur);
        logic [31:0] base;
        int          off;
        base = cur + 32'd4;
        if (jr) return rd1 - (rd1 % 4);
        if (jmp || jal) return (base & 32'hF000_0000) + (32'(instr[25:0]) * 32'd4);
        off = int'($signed(instr[15:0]));
        if ((br && zero) || (nbr && !zero)) return base + 32'(off * 4);
        return base;
    endfunction

    task automatic tick();
        mmode_t      n_mode;
        logic [31:0] n_pc, n_count;
        logic        n_prev;
        if (reset) begin
            n_mode = M_IDLE; n_pc = PC_RESET; n_count = 0; n_prev = 1'b0;
        end else begin
            n_pc    = (m_mode != M_IDLE) ? model_target(m_pc) : m_pc;
            n_count = (m_mode != M_IDLE) ? m_count + 1 : m_count;
            n_prev  = step;
            case (m_mode)
                M_IDLE:  n_mode = run_mode ? M_RUN : ((step && !m_step_prev) ? M_STEP : M_IDLE);
                M_RUN:   n_mode = run_mode ? M_RUN : M_IDLE;
                default: n_mode = M_IDLE;
            endcase
        end
        @(posedge clock);
        #1;
        m_mode = n_mode; m_pc = n_pc; m_count = n_count; m_step_prev = n_prev;
        chk("model_pc", pc_o, m_pc);
        chk("model_pc_plus4", pc_plus4_o, m_pc + 32'd4);
        chk("model_rom_adr", 32'(rom_adr_o), (m_pc >> 2) & ((32'd1 << AW) - 1));
        chk("model_commit", 32'(commit), 32'(m_mode != M_IDLE));
        chk("model_count", instr_count, m_count);
        chk("model_instr_o", Instruction_o, instr);
    endtask

    task automatic clear_inputs();
        jr = 0; jmp = 0; jal = 0; br = 0; nbr = 0; zero = 0;
        rd1 = 0; instr = 0; run_mode = 0; step = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic        run, v_jr, v_jmp, v_jal, v_br, v_nbr, v_zero;
        logic [31:0] v_instr, v_rd1, exp_pc;
        logic        exp_commit;
        logic [31:0] exp_count;
    } vec_t;

    function automatic vec_t mk(input logic r, j, jm, jl, b, nb, z,
                                input logic [31:0] ins, rd, epc,
                                input logic ec, input logic [31:0] ecnt);
        vec_t v;
        v.run = r; v.v_jr = j; v.v_jmp = jm; v.v_jal = jl; v.v_br = b; v.v_nbr = nb; v.v_zero = z;
        v.v_instr = ins; v.v_rd1 = rd; v.exp_pc = epc; v.exp_commit = ec; v.exp_count = ecnt;
        return v;
    endfunction

    vec_t vecs[20];

    initial begin
        int pulses;
        m_mode = M_IDLE; m_pc = PC_RESET; m_count = 0; m_step_prev = 0;
        reset = 1'b1;
        clear_inputs();

        do_reset();
        chk("reset_pc", pc_o, PC_RESET);
        chk("reset_commit", 32'(commit), 32'd0);
        chk("reset_count", instr_count, 32'd0);
        chk("reset_pc_plus4", pc_plus4_o, PC_RESET + 32'd4);
        chk("reset_rom_adr", 32'(rom_adr_o), 32'd0);

        //           run jr jm jl br nb z  instr          rd1            exp_pc        c  cnt
        vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0000, 1, 0);
        vecs[1]  = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0004, 1, 1);
        vecs[2]  = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0008, 1, 2);
        vecs[3]  = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_000C, 1, 3);
        vecs[4]  = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0010, 1, 4);
        vecs[5]  = mk(1, 0, 0, 0, 1, 0, 1, 32'h1000_FFFC,  32'h0,         32'h0000_0004, 1, 5);
        vecs[6]  = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0008, 1, 6);
        vecs[7]  = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_000C, 1, 7);
        vecs[8]  = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0010, 1, 8);
        vecs[9]  = mk(1, 0, 0, 0, 1, 0, 0, 32'h1000_FFFC,  32'h0,         32'h0000_0014, 1, 9);
        vecs[10] = mk(1, 0, 1, 0, 0, 0, 0, 32'h0800_0004,  32'h0,         32'h0000_0010, 1, 10);
        vecs[11] = mk(1, 0, 0, 0, 0, 1, 0, 32'h1400_FFFC,  32'h0,         32'h0000_0004, 1, 11);
        vecs[12] = mk(1, 1, 0, 0, 0, 0, 0, 32'h0,          32'h0000_0020, 32'h0000_0020, 1, 12);
        vecs[13] = mk(1, 0, 0, 1, 0, 0, 0, 32'h0C00_0040,  32'h0,         32'h0000_0100, 1, 13);
        vecs[14] = mk(1, 1, 0, 0, 0, 0, 0, 32'h0,          32'h0000_0127, 32'h0000_0124, 1, 14);
        vecs[15] = mk(1, 1, 1, 0, 0, 0, 0, 32'h0800_0080,  32'h0000_0200, 32'h0000_0200, 1, 15);
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0204, 0, 16);
        vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0204, 0, 16);
        vecs[18] = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0204, 1, 16);
        vecs[19] = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0208, 1, 17);

        for (int i = 0; i < 20; i++) begin
            run_mode = vecs[i].run; jr = vecs[i].v_jr; jmp = vecs[i].v_jmp; jal = vecs[i].v_jal;
            br = vecs[i].v_br; nbr = vecs[i].v_nbr; zero = vecs[i].v_zero;
            instr = vecs[i].v_instr; rd1 = vecs[i].v_rd1;
            if (i == 13) chk("jal_link_value", pc_plus4_o, 32'h0000_0024);
            tick();
            chk($sformatf("vec%0d_pc", i), pc_o, vecs[i].exp_pc);
            chk($sformatf("vec%0d_commit", i), 32'(commit), 32'(vecs[i].exp_commit));
            chk($sformatf("vec%0d_count", i), instr_count, vecs[i].exp_count);
        end

        do_reset();
        pulses = 0;
        step = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            pulses += int'(commit);
        end
        chk("step_held_pulses", 32'(pulses), 32'd1);
        chk("step_held_pc", pc_o, 32'h0000_0004);
        step = 1'b0; tick();
        step = 1'b1; tick();
        chk("step_again_commit", 32'(commit), 32'd1);
        step = 1'b0; tick();
        chk("step_again_pc", pc_o, 32'h0000_0008);
        chk("step_again_count", instr_count, 32'd2);
        chk("step_again_idle", 32'(commit), 32'd0);

        do_reset();
        run_mode = 1'b1; step = 1'b1;
        tick();
        chk("run_wins_commit", 32'(commit), 32'd1);
        step = 1'b0;
        jr = 1'b1; rd1 = 32'h0000_003C;
        tick();
        chk("mid_run_pc", pc_o, 32'h0000_003C);
        jr = 1'b0; reset = 1'b1;
        tick();
        chk("mid_run_reset_pc", pc_o, PC_RESET);
        chk("mid_run_reset_commit", 32'(commit), 32'd0);
        chk("mid_run_reset_count", instr_count, 32'd0);
        reset = 1'b0;
        tick();
        chk("post_reset_pc_held", pc_o, PC_RESET);
        chk("post_reset_count", instr_count, 32'd0);

        jr = 1'b1; rd1 = 32'hFFFF_FFFF;
        tick();
        chk("wrap_start_pc", pc_o, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", pc_plus4_o, 32'h0000_0000);
        jr = 1'b0;
        tick();
        chk("wrap_pc", pc_o, 32'h0000_0000);

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 15) == 0) run_mode = ~run_mode;
            if ($urandom_range(0, 2) == 0) step = ~step;
            jr   = ($urandom_range(0, 9) == 0);
            jmp  = ($urandom_range(0, 9) == 0);
            jal  = ($urandom_range(0, 12) == 0);
            br   = ($urandom_range(0, 5) == 0);
            nbr  = ($urandom_range(0, 5) == 0);
            zero = 1'($urandom);
            instr = $urandom;
            rd1   = $urandom;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage of the single-cycle MIPS core, sitting directly upstream of the instruction decoder and controller. It holds the PC and drives the instruction-ROM address. It hands the fetched word downstream: opcode [31:26] and function [5:0] go to the controller. It computes the next PC from the controller's jump/branch decisions, and gates commitment with a run/single-step FSM for board debugging.

## Interface
Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset
- ROM_ADDR_W, 14, instruction-ROM word-address width

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- rom_adr_o  out  ROM_ADDR_W  word address to instruction ROM, = PC[ROM_ADDR_W+1:2]
- Instruction_i  in  32  ROM read data, combinational from rom_adr_o
- Instruction_o  out  32  = Instruction_i, to decoder/controller
- Jr, Jmp, Jal, Branch, nBranch  in  1 each  controller decode of current instruction
- Zero  in  1  ALU zero flag of current instruction
- Read_data_1  in  32  rs value (jr target)
- pc_o  out  32  current PC
- pc_plus4_o  out  32  PC+4 (jal link value, branch base)
- run_mode  in  1  1 = free-run, 0 = single-step
- step  in  1  step request (debounced level; edge-detected internally)
- commit  out  1  current instruction commits this cycle; RegWrite/MemWrite/IOWrite are ANDed with it downstream
- instr_count  out  32  committed-instruction counter

## Operation
- Next-PC priority: Jr > (Jmp | Jal) > taken branch > PC+4.
  - Jr target = {Read_data_1[31:2], 2'b00}; low bits forced to zero.
  - Jump target = {pc_plus4[31:28], Instruction_i[25:0], 2'b00}.
  - Taken branch = (Branch & Zero) | (nBranch & ~Zero); target = pc_plus4 + {{14{imm[15]}}, imm, 2'b00}, imm = Instruction_i[15:0], modulo 2^32.
- All address arithmetic is 32-bit, wraps silently; PC 32'hFFFF_FFFC + 4 = 0.
- PC loads next-PC only on a commit cycle; otherwise PC holds.
- FSM states: IDLE, RUN, STEP.
  - IDLE: commit=0. run_mode=1 -> RUN; else step_rise -> STEP; else stay.
  - RUN: commit=1. run_mode=0 -> IDLE; else stay.
  - STEP: commit=1. Always -> IDLE.
- step_rise = step & ~step_q, where step_q is step registered. Holding step high yields exactly one STEP.
- run_mode and step both active in IDLE: run_mode wins.
- instr_count increments by 1 on every commit cycle, wraps 32'hFFFF_FFFF -> 0.

## Timing
- Reset values: PC = PC_RESET, state = IDLE, commit = 0, instr_count = 0, step_q = 0. rom_adr_o = PC_RESET[ROM_ADDR_W+1:2], pc_plus4_o = PC_RESET+4.
- Instruction_o, pc_plus4_o and rom_adr_o are combinational from PC, so they are valid the same cycle the PC changes. The instruction is available zero cycles after the PC edge.
- commit is a function of the registered state only (no combinational path from run_mode/step).
- Next-PC is registered at the edge ending a commit cycle: a branch or jump taken in cycle N shows its target on pc_o in cycle N+1. No delay slot.
- Dropping run_mode in RUN: the cycle where run_mode is first seen low still commits; IDLE follows next edge.
- Step latency: step rises in cycle N -> STEP in N+1 (commit=1) -> IDLE in N+2. A new step needs step low for at least one cycle.
- Reset asserted mid-RUN or mid-STEP: next edge forces reset values; reset dominates all other inputs. No commit occurs in the cycle after reset.

## Test plan
- Reset, then run_mode=1 with ROM of NOPs -> pc_o reads 0, 4, 8, 12 on successive cycles starting the cycle after RUN is entered; instr_count tracks 0, 1, 2, 3.
- Branch at PC 0x10 with imm=16'hFFFC, Zero=1 -> next pc_o = 0x04. Same with Zero=0 -> 0x14. nBranch with Zero=0 -> 0x04.
- Jal with Instruction_i[25:0]=26'h0000_040 at PC 0x20 -> pc_plus4_o = 0x24 during the cycle; next pc_o = 0x100. Jr with Read_data_1=0x0000_0127 -> next pc_o = 0x124. Jr and Jmp both high -> Jr target taken.
- run_mode=0, step held high 5 cycles -> exactly one commit pulse, PC advances by 4 once. Release and re-press -> second single advance. instr_count = 2.
- Drop run_mode in RUN -> exactly one further commit, then commit=0 and PC frozen; re-assert run_mode -> resumes from frozen PC.
- Assert reset for one cycle while in RUN at PC 0x3C -> pc_o = PC_RESET, commit=0, instr_count=0 next cycle. Force PC wrap from 0xFFFF_FFFC -> 0x0.
